huffman_gen: RTL and testbench

- Parametrised successor of the fixed 6-symbol, 100-sample Huffman block.
- Accumulates a histogram of NSYM symbol values over a TOTAL-sample frame.
- Publishes the counts, then builds the Huffman code iteratively, one merge per cycle, and publishes per-symbol codewords and masks.
- Re-arms automatically for back-to-back frames; sits between the gray-level source and the entropy-coder packer.

---
 rtl/huffman_gen.sv | 175 +++++++++++++++++
 tb/tb_huffman_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/huffman_gen.sv
// Histogram + iterative Huffman code builder: counts a TOTAL-sample frame of
// symbols 1..NSYM, then merges the two smallest groups per cycle to form codes.
module huffman_gen #(
  parameter int NSYM   = 6,
  parameter int TOTAL  = 100,
  parameter int CW     = 8,
  parameter int CODE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gray_valid,
  input  logic [7:0]               gray_data,
  output logic                     busy,
  output logic                     drop,
  output logic                     CNT_valid,
  output logic [NSYM*CW-1:0]       CNT,
  output logic                     code_valid,
  output logic [NSYM*CODE_W-1:0]   HC,
  output logic [NSYM*CODE_W-1:0]   M
);

  localparam int IW = $clog2(NSYM);
  localparam int LW = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {COUNT, CNT_OUT, BUILD, CODE_OUT} state_t;

  state_t state, state_d;

  logic [CW-1:0]     count     [NSYM];
  logic [CW-1:0]     count_inc [NSYM];
  logic [CW-1:0]     total;
  logic [CW-1:0]     g_cnt     [NSYM];
  logic [IW-1:0]     g_key     [NSYM];
  logic [NSYM-1:0]   g_act;
  logic [IW-1:0]     grp       [NSYM];
  logic [LW-1:0]     len       [NSYM];
  logic [CODE_W-1:0] hc        [NSYM];
  logic [CODE_W-1:0] m         [NSYM];
  logic [IW-1:0]     step;
  logic [IW-1:0]     l1, l2;
  logic              have1, have2;
  logic              in_range, accept, last;

  assign in_range = gray_valid && (gray_data != 8'd0) && (gray_data <= 8'(NSYM));
  assign accept   = (state == COUNT) && in_range;
  assign last     = accept && (total == CW'(TOTAL - 1));
  assign busy     = (state != COUNT);

  always_comb begin
    for (int s = 0; s < NSYM; s++) begin
      count_inc[s] = count[s] + ((accept && gray_data == 8'(s + 1)) ? CW'(1) : CW'(0));
    end
  end

  // Ordering: lower count first; equal counts resolve with the higher key as smaller.
  function automatic logic smaller(input logic [CW-1:0] ca, input logic [IW-1:0] ka,
                                   input logic [CW-1:0] cb, input logic [IW-1:0] kb);
    return (ca < cb) || ((ca == cb) && (ka > kb));
  endfunction

  always_comb begin
    l1    = '0;
    l2    = '0;
    have1 = 1'b0;
    have2 = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (g_act[i]) begin
        if (!have1 || smaller(g_cnt[i], g_key[i], g_cnt[l1], g_key[l1])) begin
          l2    = l1;
          have2 = have1;
          l1    = IW'(i);
          have1 = 1'b1;
        end else if (!have2 || smaller(g_cnt[i], g_key[i], g_cnt[l2], g_key[l2])) begin
          l2    = IW'(i);
          have2 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      COUNT:    if (last) state_d = CNT_OUT;
      CNT_OUT:  state_d = BUILD;
      BUILD:    if (step == IW'(NSYM - 2)) state_d = CODE_OUT;
      CODE_OUT: state_d = COUNT;
      default:  state_d = COUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COUNT;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total      <= '0;
      step       <= '0;
      g_act      <= '0;
      CNT        <= '0;
      HC         <= '0;
      M          <= '0;
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      drop       <= 1'b0;
      for (int s = 0; s < NSYM; s++) begin
        count[s] <= '0;
        g_cnt[s] <= '0;
        g_key[s] <= '0;
        grp[s]   <= '0;
        len[s]   <= '0;
        hc[s]    <= '0;
        m[s]     <= '0;
      end
    end else begin
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      drop       <= busy && in_range;
      case (state)
        COUNT: begin
          if (accept) begin
            total <= total + CW'(1);
            for (int s = 0; s < NSYM; s++) count[s] <= count_inc[s];
          end
          // The published bus includes the final sample's increment.
          if (last) begin
            CNT_valid <= 1'b1;
            for (int s = 0; s < NSYM; s++) CNT[s*CW +: CW] <= count_inc[s];
          end
        end
        CNT_OUT: begin
          step  <= '0;
          g_act <= '1;
          for (int s = 0; s < NSYM; s++) begin
            g_cnt[s] <= count[s];
            g_key[s] <= IW'(s);
            grp[s]   <= IW'(s);
            len[s]   <= '0;
            hc[s]    <= '0;
            m[s]     <= '0;
          end
        end
        BUILD: begin
          step       <= step + IW'(1);
          g_cnt[l2]  <= g_cnt[l2] + g_cnt[l1];
          g_key[l2]  <= (g_key[l1] < g_key[l2]) ? g_key[l1] : g_key[l2];
          g_act[l1]  <= 1'b0;
          for (int s = 0; s < NSYM; s++) begin
            if (grp[s] == l1 || grp[s] == l2) begin
              m[s]   <= m[s] | (CODE_W'(1) << len[s]);
              len[s] <= len[s] + LW'(1);
            end
            if (grp[s] == l1) begin
              hc[s]  <= hc[s] | (CODE_W'(1) << len[s]);
              grp[s] <= l2;
            end
          end
        end
        CODE_OUT: begin
          code_valid <= 1'b1;
          total      <= '0;
          for (int s = 0; s < NSYM; s++) begin
            HC[s*CODE_W +: CODE_W] <= hc[s];
            M[s*CODE_W +: CODE_W]  <= m[s];
            count[s]               <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_gen.sv
// Directed bench for huffman_gen: default 6-symbol instance plus a 4-symbol,
// 16-sample instance, with hand-computed counts, codewords and masks.
module tb_huffman_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        gray_valid;
  logic [7:0]  gray_data;
  logic        busy, drop, cnt_valid, code_valid;
  logic [47:0] cnt, hc, m;

  logic        b_valid;
  logic [7:0]  b_data;
  logic        b_busy, b_drop, b_cnt_valid, b_code_valid;
  logic [31:0] b_cnt, b_hc, b_m;

  huffman_gen dut_a (
    .clk(clk), .reset(rst), .gray_valid(gray_valid), .gray_data(gray_data),
    .busy(busy), .drop(drop), .CNT_valid(cnt_valid), .CNT(cnt),
    .code_valid(code_valid), .HC(hc), .M(m)
  );

  huffman_gen #(.NSYM(4), .TOTAL(16), .CW(8), .CODE_W(8)) dut_b (
    .clk(clk), .reset(rst), .gray_valid(b_valid), .gray_data(b_data),
    .busy(b_busy), .drop(b_drop), .CNT_valid(b_cnt_valid), .CNT(b_cnt),
    .code_valid(b_code_valid), .HC(b_hc), .M(b_m)
  );

  int checks = 0;
  int failures = 0;
  int code_pulses = 0;
  int drop_cnt = 0;

  always @(negedge clk) begin
    if (code_valid) code_pulses++;
    if (drop) drop_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    gray_valid = v;
    gray_data  = d;
    @(posedge clk);
    #1;
    gray_valid = 1'b0;
    gray_data  = 8'd0;
  endtask

  task automatic drive_b(input logic [7:0] d);
    b_valid = 1'b1;
    b_data  = d;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_data  = 8'd0;
  endtask

  // Round-robin over symbols; optional out-of-range and idle samples interleaved.
  task automatic send_frame(input string name, input logic [47:0] counts, input bit noise);
    int rem [6];
    logic [7:0] nv [3];
    int n = 0;
    int early = 0;
    nv[0] = 8'd0; nv[1] = 8'd7; nv[2] = 8'd255;
    for (int s = 0; s < 6; s++) rem[s] = int'(counts[s*8 +: 8]);
    while (n < 100) begin
      for (int s = 0; s < 6; s++) begin
        if (rem[s] > 0) begin
          drive(1'b1, 8'(s + 1));
          rem[s]--;
          n++;
          if (cnt_valid && n < 100) early++;
          if (noise && n < 100 && n % 9 == 0) begin
            drive(1'b1, nv[(n / 9) % 3]);
            drive(1'b0, 8'(s + 1));
            if (cnt_valid) early++;
          end
        end
      end
    end
    check({name, "_early_cnt_valid"}, 64'(early), 64'd0);
  endtask

  task automatic wait_code(input string name, input int exp_lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!code_valid && k < 20);
    check({name, "_code_latency"}, 64'(k), 64'(exp_lat));
  endtask

  task automatic run_frame(input string name, input logic [47:0] counts,
                           input logic [47:0] hc_e, input logic [47:0] m_e, input bit noise);
    send_frame(name, counts, noise);
    @(negedge clk);
    check({name, "_cnt_valid"}, 64'(cnt_valid), 64'd1);
    check({name, "_cnt"}, 64'(cnt), 64'(counts));
    check({name, "_busy_cnt_out"}, 64'(busy), 64'd1);
    wait_code(name, 7);
    check({name, "_hc"}, 64'(hc), 64'(hc_e));
    check({name, "_m"}, 64'(m), 64'(m_e));
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [47:0] counts;
    logic [47:0] hc;
    logic [47:0] m;
    bit          noise;
  } vec_t;

  vec_t tbl [3];
  logic [47:0] f1_counts, f1_hc, f1_m;

  initial begin
    f1_counts = 48'h0A_0A_0F_0F_14_1E;
    f1_hc     = 48'h07_06_03_02_02_00;
    f1_m      = 48'h07_07_07_07_03_03;
    tbl[0] = '{"mixed", f1_counts, f1_hc, f1_m, 1'b0};
    tbl[1] = '{"all_sym1", 48'h00_00_00_00_00_64, 48'h1F_1E_0E_06_02_00, 48'h1F_1F_0F_07_03_01, 1'b0};
    tbl[2] = '{"noisy", f1_counts, f1_hc, f1_m, 1'b1};

    rst = 1'b1;
    gray_valid = 1'b0; gray_data = 8'd0;
    b_valid = 1'b0; b_data = 8'd0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_cnt_valid", 64'(cnt_valid), 64'd0);
    check("rst_code_valid", 64'(code_valid), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_hc", 64'(hc), 64'd0);
    check("rst_m", 64'(m), 64'd0);
    check("rst_b_cnt", 64'(b_cnt), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      run_frame(tbl[i].name, tbl[i].counts, tbl[i].hc, tbl[i].m, tbl[i].noise);
    end

    // Samples arriving from CNT_OUT through CODE_OUT are all dropped.
    begin
      int n = 0;
      send_frame("busy_frame", f1_counts, 1'b0);
      do begin
        drive(1'b1, 8'd1);
        n++;
      end while (!code_valid && n < 20);
      check("busy_samples", 64'(n), 64'd7);
      repeat (2) @(posedge clk);
      #1;
      check("drop_pulses", 64'(drop_cnt), 64'd7);
      check("busy_frame_hc", 64'(hc), 64'(f1_hc));
    end
    run_frame("second", 48'h00_00_19_19_19_19, 48'h0F_0E_06_02_01_00, 48'h0F_0F_07_03_03_03, 1'b0);

    // Asynchronous reset in the middle of BUILD.
    begin
      int cp;
      send_frame("rst_frame", f1_counts, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_cnt", 64'(cnt), 64'd0);
      check("mid_rst_hc", 64'(hc), 64'd0);
      check("mid_rst_m", 64'(m), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      cp = code_pulses;
      repeat (12) @(posedge clk);
      #1;
      check("mid_rst_no_code", 64'(code_pulses), 64'(cp));
    end
    run_frame("after_rst", f1_counts, f1_hc, f1_m, 1'b0);

    // Four-symbol instance, counts 8/4/2/2.
    begin
      int rem [4];
      int k = 0;
      rem[0] = 8; rem[1] = 4; rem[2] = 2; rem[3] = 2;
      for (int r = 0; r < 8; r++) begin
        for (int s = 0; s < 4; s++) begin
          if (rem[s] > 0) begin
            drive_b(8'(s + 1));
            rem[s]--;
          end
        end
      end
      @(negedge clk);
      check("b_cnt_valid", 64'(b_cnt_valid), 64'd1);
      check("b_cnt", 64'(b_cnt), 64'h02_02_04_08);
      do begin
        @(negedge clk);
        k++;
      end while (!b_code_valid && k < 20);
      check("b_code_latency", 64'(k), 64'd5);
      check("b_hc", 64'(b_hc), 64'h07_06_02_00);
      check("b_m", 64'(b_m), 64'h07_07_03_01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
